// File: rtl/accuracy_monitor.sv
// rtl/accuracy_monitor.sv - DNN output-layer accuracy monitor: per-case scoring, sliding window, totals, epochs
// Optional per-case squared error output enabled by defining ACC_MON_SQERR_EN.
module accuracy_monitor #(
  parameter int NOUT        = 16,
  parameter int P           = 1,
  parameter int NCLS        = 10,
  parameter int DW          = 12,
  parameter int WINDOW      = 1000,
  parameter int EPOCH_CASES = 10000,
  parameter int MODE        = 0,
  localparam int RW         = $clog2(WINDOW + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic [P-1:0]                    a_bit,
  input  logic [P-1:0]                    y_bit,
  input  logic [P*DW-1:0]                 act,
  input  logic [P*DW-1:0]                 delta,
  output logic                            case_done,
  output logic                            case_correct,
  output logic                            len_err,
  output logic [RW-1:0]                   recent_cnt,
  output logic [31:0]                     total_cnt,
  output logic [31:0]                     case_cnt,
  output logic [15:0]                     epoch_cnt,
  output logic                            epoch_done
`ifdef ACC_MON_SQERR_EN
  ,
  output logic [2*DW+$clog2(NOUT)-1:0]    sqerr
`endif
);

  localparam int NB = NOUT / P;
  localparam int GW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = (EPOCH_CASES > 1) ? $clog2(EPOCH_CASES) : 1;

  logic [GW-1:0]        g;
  logic                 mism, have_max, max_y, bad;
  logic signed [DW-1:0] max_act;
  logic [WINDOW-1:0]    wbuf;
  logic [PW-1:0]        wptr;
  logic [EW-1:0]        ep_pos;

  logic                 nxt_mism, nxt_have, nxt_max_y;
  logic signed [DW-1:0] nxt_max, lane_act;
  logic                 last_g, correct;

  // Lanes are folded in ascending index order so the strict compare keeps the lowest index on ties.
  always_comb begin
    nxt_mism  = mism;
    nxt_have  = have_max;
    nxt_max   = max_act;
    nxt_max_y = max_y;
    lane_act  = '0;
    for (int k = 0; k < P; k++) begin
      lane_act = act[k*DW +: DW];
      if (a_bit[k] != y_bit[k]) nxt_mism = 1'b1;
      if ((int'(g) * P + k < NCLS) && (!nxt_have || lane_act > nxt_max)) begin
        nxt_have  = 1'b1;
        nxt_max   = lane_act;
        nxt_max_y = y_bit[k];
      end
    end
  end

  assign last_g  = (g == GW'(NB - 1));
  assign correct = last_g && !bad && ((MODE == 0) ? !nxt_mism : nxt_max_y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g <= '0; mism <= 1'b0; have_max <= 1'b0; max_y <= 1'b0; bad <= 1'b0; max_act <= '0;
      wbuf <= '0; wptr <= '0; ep_pos <= '0;
      case_done <= 1'b0; case_correct <= 1'b0; len_err <= 1'b0; recent_cnt <= '0;
      total_cnt <= '0; case_cnt <= '0; epoch_cnt <= '0; epoch_done <= 1'b0;
    end else if (clear) begin
      g <= '0; mism <= 1'b0; have_max <= 1'b0; max_y <= 1'b0; bad <= 1'b0; max_act <= '0;
      wbuf <= '0; wptr <= '0; ep_pos <= '0;
      case_done <= 1'b0; case_correct <= 1'b0; len_err <= 1'b0; recent_cnt <= '0;
      total_cnt <= '0; case_cnt <= '0; epoch_cnt <= '0; epoch_done <= 1'b0;
    end else begin
      case_done  <= 1'b0;
      epoch_done <= 1'b0;
      if (in_valid && in_last) begin
        g <= '0; mism <= 1'b0; have_max <= 1'b0; max_y <= 1'b0; bad <= 1'b0; max_act <= '0;
        if (!last_g) len_err <= 1'b1;
        case_done    <= 1'b1;
        case_correct <= correct;
        recent_cnt   <= recent_cnt - RW'(wbuf[wptr]) + RW'(correct);
        wbuf[wptr]   <= correct;
        wptr         <= (wptr == PW'(WINDOW - 1)) ? '0 : wptr + 1'b1;
        total_cnt    <= total_cnt + {31'd0, correct};
        case_cnt     <= case_cnt + 32'd1;
        if (ep_pos == EW'(EPOCH_CASES - 1)) begin
          ep_pos     <= '0;
          epoch_cnt  <= epoch_cnt + 16'd1;
          epoch_done <= 1'b1;
        end else begin
          ep_pos <= ep_pos + 1'b1;
        end
      end else if (in_valid) begin
        mism     <= nxt_mism;
        have_max <= nxt_have;
        max_act  <= nxt_max;
        max_y    <= nxt_max_y;
        // Overlong case: hold the beat counter and poison the case until in_last arrives.
        if (last_g) begin
          bad     <= 1'b1;
          len_err <= 1'b1;
        end else begin
          g <= g + 1'b1;
        end
      end
    end
  end

`ifdef ACC_MON_SQERR_EN
  localparam int SQW = 2 * DW + $clog2(NOUT);
  logic [SQW-1:0]         acc, beat_sq;
  logic signed [2*DW-1:0] prod;

  always_comb begin
    beat_sq = '0;
    prod    = '0;
    for (int k = 0; k < P; k++) begin
      prod    = $signed(delta[k*DW +: DW]) * $signed(delta[k*DW +: DW]);
      beat_sq = beat_sq + {{(SQW-2*DW){1'b0}}, prod};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      sqerr <= '0;
    end else if (clear) begin
      acc   <= '0;
      sqerr <= '0;
    end else if (in_valid) begin
      if (in_last) begin
        sqerr <= acc + beat_sq;
        acc   <= '0;
      end else begin
        acc <= acc + beat_sq;
      end
    end
  end
`else
  logic unused_delta;
  assign unused_delta = ^delta;
`endif

endmodule

// File: tb/tb_accuracy_monitor.sv
// tb/tb_accuracy_monitor.sv - scoreboard bench for accuracy_monitor, MODE 0 and MODE 1 instances on shared stimulus
module tb_accuracy_monitor;
  localparam int NOUT = 16;
  localparam int DW   = 12;
  localparam int RW   = 3;
  localparam int SQW  = 2 * DW + 4;

  typedef struct {
    bit              correct;
    logic [RW-1:0]   recent;
    logic [31:0]     total;
    logic [31:0]     cases;
    logic [15:0]     epochs;
    bit              epoch_done;
    bit              len_err;
    logic [SQW-1:0]  sq;
    int              due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0, clear = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [0:0]    a_bit = '0, y_bit = '0;
  logic [DW-1:0] act = '0, delta = '0;

  logic          case_done [2];
  logic          case_correct [2];
  logic          len_err [2];
  logic [RW-1:0] recent_cnt [2];
  logic [31:0]   total_cnt [2];
  logic [31:0]   case_cnt [2];
  logic [15:0]   epoch_cnt [2];
  logic          epoch_done [2];
`ifdef ACC_MON_SQERR_EN
  logic [SQW-1:0] sqerr [2];
`endif

  for (genvar m = 0; m < 2; m++) begin : g_dut
    accuracy_monitor #(
      .NOUT(NOUT), .P(1), .NCLS(10), .DW(DW), .WINDOW(4), .EPOCH_CASES(3), .MODE(m)
    ) u_dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_last(in_last),
      .a_bit(a_bit), .y_bit(y_bit), .act(act), .delta(delta),
      .case_done(case_done[m]), .case_correct(case_correct[m]), .len_err(len_err[m]),
      .recent_cnt(recent_cnt[m]), .total_cnt(total_cnt[m]), .case_cnt(case_cnt[m]),
      .epoch_cnt(epoch_cnt[m]), .epoch_done(epoch_done[m])
`ifdef ACC_MON_SQERR_EN
      , .sqerr(sqerr[m])
`endif
    );
  end

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0, negcnt = 0;
  exp_t q0[$], q1[$];
  bit hist [2][64];
  int ncase [2];
  int ntotal [2];
  bit lenm [2];
  logic [DW-1:0] acts [16];
  logic [DW-1:0] dls [16];

  task automatic chk(input string name, input int m, input logic [63:0] got, input logic [63:0] exp_v);
    nchk++;
    if (got !== exp_v) begin
      nfail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, m, got, exp_v);
    end
  endtask

  function automatic bit q_empty(input int m);
    return (m == 0) ? (q0.size() == 0) : (q1.size() == 0);
  endfunction

  function automatic exp_t q_pop(input int m);
    if (m == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int q_due(input int m);
    return (m == 0) ? q0[0].due : q1[0].due;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ncase[m] = 0; ntotal[m] = 0; lenm[m] = 1'b0;
    end
  endtask

  task automatic expect_case(input int m, input bit corr, input bit bad_len, input logic [SQW-1:0] sq);
    exp_t e;
    int rec;
    hist[m][ncase[m]] = corr;
    ncase[m]++;
    ntotal[m] += int'(corr);
    if (bad_len) lenm[m] = 1'b1;
    rec = 0;
    for (int j = 0; j < 4 && j < ncase[m]; j++) rec += int'(hist[m][ncase[m]-1-j]);
    e.correct    = corr;
    e.recent     = RW'(rec);
    e.total      = 32'(ntotal[m]);
    e.cases      = 32'(ncase[m]);
    e.epochs     = 16'(ncase[m] / 3);
    e.epoch_done = (ncase[m] % 3 == 0);
    e.len_err    = lenm[m];
    e.sq         = sq;
    e.due        = negcnt + 1;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    negcnt++;
    for (int m = 0; m < 2; m++) begin
      if (case_done[m]) begin
        if (q_empty(m)) begin
          chk("spurious_case_done", m, 64'd1, 64'd0);
        end else begin
          e = q_pop(m);
          chk("done_latency", m, 64'(negcnt), 64'(e.due));
          chk("case_correct", m, 64'(case_correct[m]), 64'(e.correct));
          chk("recent_cnt", m, 64'(recent_cnt[m]), 64'(e.recent));
          chk("total_cnt", m, 64'(total_cnt[m]), 64'(e.total));
          chk("case_cnt", m, 64'(case_cnt[m]), 64'(e.cases));
          chk("epoch_cnt", m, 64'(epoch_cnt[m]), 64'(e.epochs));
          chk("epoch_done", m, 64'(epoch_done[m]), 64'(e.epoch_done));
          chk("len_err", m, 64'(len_err[m]), 64'(e.len_err));
`ifdef ACC_MON_SQERR_EN
          chk("sqerr", m, 64'(sqerr[m]), 64'(e.sq));
`endif
        end
      end else begin
        if (epoch_done[m]) chk("epoch_done_alone", m, 64'd1, 64'd0);
        if (!q_empty(m) && q_due(m) < negcnt) begin
          e = q_pop(m);
          chk("missed_case_done", m, 64'd0, 64'd1);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_case_done"}, m, 64'(case_done[m]), 64'd0);
      chk({tag, "_case_correct"}, m, 64'(case_correct[m]), 64'd0);
      chk({tag, "_len_err"}, m, 64'(len_err[m]), 64'd0);
      chk({tag, "_recent_cnt"}, m, 64'(recent_cnt[m]), 64'd0);
      chk({tag, "_total_cnt"}, m, 64'(total_cnt[m]), 64'd0);
      chk({tag, "_case_cnt"}, m, 64'(case_cnt[m]), 64'd0);
      chk({tag, "_epoch_cnt"}, m, 64'(epoch_cnt[m]), 64'd0);
      chk({tag, "_epoch_done"}, m, 64'(epoch_done[m]), 64'd0);
`ifdef ACC_MON_SQERR_EN
      chk({tag, "_sqerr"}, m, 64'(sqerr[m]), 64'd0);
`endif
    end
  endtask

  task automatic set_acts(input logic [DW-1:0] base);
    for (int i = 0; i < 16; i++) begin
      acts[i] = base;
      dls[i]  = '0;
    end
  endtask

  task automatic run_case(input logic [15:0] a, input logic [15:0] y, input int nbeats,
                          input bit c0, input bit c1, input int gap_at, input logic [SQW-1:0] sq);
    bit bad;
    int idx;
    bad = (nbeats != 16);
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin
        repeat (2) begin
          @(negedge clk); #2;
          in_valid = 1'b0; in_last = 1'b0;
        end
      end
      @(negedge clk); #2;
      idx = (b < 16) ? b : 15;
      in_valid = 1'b1;
      in_last  = (b == nbeats - 1);
      a_bit    = a[idx];
      y_bit    = y[idx];
      act      = acts[idx];
      delta    = dls[idx];
      if (in_last) begin
        expect_case(0, bad ? 1'b0 : c0, bad, sq);
        expect_case(1, bad ? 1'b0 : c1, bad, sq);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #2;
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    #1 reset = 1'b1;

    // Back-to-back cases 1..3; MODE 0 pattern 1,1,0,1,0,0 then 1.
    set_acts('0); acts[3] = 12'd100; acts[12] = 12'd500;
    dls[2] = 12'h100; dls[5] = 12'h100; dls[8] = 12'h100; dls[11] = 12'h100;
    run_case(16'h0008, 16'h0008, 16, 1'b1, 1'b1, -1, SQW'(262144));
    set_acts('0); acts[3] = 12'd50; acts[5] = 12'd50;
    run_case(16'h0020, 16'h0020, 16, 1'b1, 1'b0, -1, '0);
    set_acts('0); acts[3] = 12'd7;
    run_case(16'h0001, 16'h0008, 16, 1'b0, 1'b1, -1, '0);
    set_acts(12'hFFB); acts[9] = 12'd2;
    run_case(16'hFDFF, 16'hFDFF, 16, 1'b1, 1'b0, 7, '0);
    set_acts('0); acts[0] = 12'd1;
    run_case(16'h0000, 16'h0400, 16, 1'b0, 1'b0, -1, '0);
    set_acts('0);
    run_case(16'h8000, 16'h0000, 16, 1'b0, 1'b0, -1, '0);
    set_acts('0); acts[1] = 12'd3;
    run_case(16'h0002, 16'h0002, 16, 1'b1, 1'b1, -1, '0);
    idle(1);

    // Short case (in_last on beat 10), a good case, then an overlong case.
    set_acts('0); acts[0] = 12'd9;
    run_case(16'h0001, 16'h0001, 11, 1'b1, 1'b1, -1, '0);
    set_acts('0); acts[1] = 12'd3;
    run_case(16'h0002, 16'h0002, 16, 1'b1, 1'b1, -1, '0);
    run_case(16'h0002, 16'h0002, 18, 1'b1, 1'b1, -1, '0);
    idle(3);

    // Clear coincident with a beat: clear wins, everything returns to zero.
    @(negedge clk); #2;
    clear = 1'b1; in_valid = 1'b1; in_last = 1'b1; a_bit = 1'b0; y_bit = 1'b1;
    @(negedge clk); #2;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_reset();
    @(negedge clk); #1;
    chk_zero("clear");

    run_case(16'h0002, 16'h0002, 16, 1'b1, 1'b1, -1, '0);
    idle(3);

    // Asynchronous reset in the middle of a case.
    for (int b = 0; b < 5; b++) begin
      @(negedge clk); #2;
      in_valid = 1'b1; in_last = 1'b0; a_bit = 1'b1; y_bit = 1'b0; act = 12'd4; delta = 12'h040;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk_zero("async_reset");
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    set_acts('0); acts[1] = 12'd3;
    run_case(16'h0002, 16'h0002, 16, 1'b1, 1'b1, -1, '0);
    idle(5);
    chk("scoreboard_drain", 0, 64'(q0.size() + q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/accuracy_monitor.md
# accuracy_monitor

Synthesizable on-chip training-accuracy monitor for the DNN output layer. Consumes the per-clock output-neuron stream (actual bit, ideal bit, activation, delta), decides per training case whether the network was correct, and maintains a sliding-window correct count, lifetime totals and epoch boundaries in hardware. It sits beside the `DNN` output layer, replacing bench-side scoring so accuracy is observable in silicon and in long regressions.

## Interface
- `NOUT`, 16: output neurons per case.
- `P`, 1: neurons delivered per beat; `NOUT % P == 0`.
- `NCLS`, 10: class neurons (indices `0..NCLS-1`); higher indices are padding.
- `DW`, 12: width of `act`/`delta` words, two's complement.
- `WINDOW`, 1000: sliding-window depth in cases.
- `EPOCH_CASES`, 10000: cases per epoch.
- `MODE`, 0: 0 = exact match on all `NOUT` bits; 1 = argmax over classes.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of all counters and window.
- `in_valid` in 1: beat qualifier.
- `in_last` in 1: final beat of a case.
- `a_bit` in P: thresholded actual outputs.
- `y_bit` in P: ideal outputs.
- `act` in P*DW: unthresholded activations (MODE 1).
- `delta` in P*DW: a−y per neuron.
- `case_done` out 1: one-cycle pulse, case scored.
- `case_correct` out 1: result of last scored case.
- `len_err` out 1: sticky, malformed case seen.
- `recent_cnt` out clog2(WINDOW+1): correct cases among last `WINDOW`.
- `total_cnt` out 32: correct cases since reset/clear.
- `case_cnt` out 32: scored cases since reset/clear.
- `epoch_cnt` out 16: completed epochs.
- `epoch_done` out 1: one-cycle pulse coincident with the `case_done` closing an epoch.
- `sqerr` out 2*DW+clog2(NOUT): only with `ACC_MON_SQERR_EN`.

## Operation
- Beat counter `g` (0..NOUT/P−1) tracks neuron index `g*P+k` for lane k; advances on `in_valid`, returns to 0 after `in_last`.
- Running state per case: `mism` (any `a_bit!=y_bit`), running max `act` and its index (classes only, signed compare, strict `>` so lowest index wins ties), ideal bit at current max.
- On `in_valid & in_last`: correct = MODE 0 ? `!mism` : `y_bit[argmax]==1`. If `g != NOUT/P−1`, case forced incorrect and `len_err` set. Beats with `g == NOUT/P−1` and no `in_last`: case forced incorrect, `len_err` set, counter holds until `in_last`.
- Window: WINDOW-bit circular buffer, write pointer wraps at `WINDOW−1`. Per case: `recent_cnt <= recent_cnt − buf[ptr] + correct`, `buf[ptr] <= correct`. Unfilled entries read 0.
- `case_cnt`, `total_cnt` wrap at 2^32. Epoch counter of cases wraps at `EPOCH_CASES−1`; on wrap `epoch_cnt++`, `epoch_done` pulses.
- `clear` and `reset` zero every register, buffer, pointer and `len_err`; partial case discarded. `clear` with `in_valid` same cycle: clear wins, beat dropped.

## Timing
- All outputs registered; reset values all 0.
- `case_done`, `case_correct`, `recent_cnt`, `total_cnt`, `case_cnt`, `epoch_*`, `sqerr` update on the clock edge following the `in_last` beat (latency 1).
- Back-to-back cases supported: `in_last` followed immediately by next case's first beat, no bubble.
- Gaps (`in_valid` low) allowed anywhere; state holds.

## Configuration
- `ACC_MON_SQERR_EN` defined: per-case `sqerr = Σ delta²` over all `NOUT` neurons (signed multiply, unsigned sum, no saturation), registered with `case_done`; one DW×DW multiplier per lane.
- Undefined: `sqerr` port and multipliers absent; no other behaviour change.

## Test plan
- MODE 0, P=1, 16 matching beats, `in_last` on beat 15 -> `case_done` one cycle later, `case_correct=1`, `recent_cnt=1`, `total_cnt=1`.
- MODE 1, act max at index 3 with `y_bit[3]=1`, padding index 12 larger -> correct=1; tie at indices 3 and 5 with `y_bit[5]=1` only -> correct=0.
- WINDOW=4, pattern 1,1,0,1,0,0 -> `recent_cnt` 1,2,2,3,2,1.
- EPOCH_CASES=3, 7 cases -> `epoch_done` on cases 3 and 6, `epoch_cnt=2`, `case_cnt=7`.
- `in_last` on beat 10 of 16 -> case incorrect, `len_err=1` until `clear`; next well-formed case scores normally.
- With `ACC_MON_SQERR_EN`, DW=12, deltas 0x100 (0.5 at FRAC 9) on 4 neurons, else 0 -> `sqerr=4*65536=262144`; `reset` low mid-case -> all outputs 0 asynchronously.
